// File: rtl/lamp_mode_scheduler.sv
// Lamp sequencer: debounces the panel switches, resolves the LED mode and display
// code, and time-shares the three shade servos with dead time between grants.
module lamp_mode_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned SLOT_CYCLES       = 50000000,
  parameter int unsigned GAP_CYCLES        = 2500000,
  parameter int unsigned BLINK_HALF_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sw_i,
  output logic [2:0] motor_en_o,
  output logic       motor_busy_o,
  output logic [3:0] led_o,
  output logic       led_pwm_sel_o,
  output logic [3:0] mode_o
);

  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES   > 1) ? $clog2(DEBOUNCE_CYCLES)   : 1;
  localparam int unsigned SLOT_W  = (SLOT_CYCLES       > 1) ? $clog2(SLOT_CYCLES)       : 1;
  localparam int unsigned GAP_W   = (GAP_CYCLES        > 1) ? $clog2(GAP_CYCLES)        : 1;
  localparam int unsigned BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

  logic [9:0]         sync1, sync2, deb;
  logic [DB_W-1:0]    db_cnt [10];
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_off;
  logic [3:0]         disp_code;
  logic [3:0]         led_next;
  logic               sel_next;
  logic               blink_mode;

  state_t             state;
  logic [1:0]         grant;
  logic [SLOT_W-1:0]  slot_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [2:0]         req;
  logic [2:0]         grant_mask;
  logic [1:0]         cand1, cand2, rr_pick;
  logic               rr_found, others_req;

  function automatic logic [1:0] wrap_inc(input logic [1:0] g);
    return (g == 2'd2) ? 2'd0 : g + 2'd1;
  endfunction

  // A bit is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int unsigned i = 0; i < 10; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= sw_i;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 10; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    disp_code = 4'hA;
    for (int unsigned i = 0; i < 10; i++)
      if (deb[i]) disp_code = 4'(i);
  end

  always_comb begin
    led_next   = '0;
    sel_next   = 1'b0;
    blink_mode = 1'b0;
    if (deb[6])      led_next = 4'b0001;
    else if (deb[5]) led_next = 4'b0010;
    else if (deb[4]) led_next = 4'b0100;
    else if (deb[3]) led_next = 4'b1000;
    else if (deb[2]) led_next = 4'b1111;
    else if (deb[1]) begin
      blink_mode = 1'b1;
      led_next   = blink_off ? 4'b0000 : 4'b1111;
    end else if (deb[0]) sel_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_o        <= 4'hA;
      led_o         <= '0;
      led_pwm_sel_o <= 1'b0;
      blink_cnt     <= '0;
      blink_off     <= 1'b0;
    end else begin
      mode_o        <= disp_code;
      led_o         <= led_next;
      led_pwm_sel_o <= sel_next;
      if (!blink_mode) begin
        blink_cnt <= '0;
        blink_off <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Servo 0 is SW9, servo 2 is SW7; search starts just after the last grant.
  always_comb begin
    req        = {deb[7], deb[8], deb[9]};
    grant_mask = 3'b001 << grant;
    others_req = |(req & ~grant_mask);
    cand1      = wrap_inc(grant);
    cand2      = wrap_inc(cand1);
    rr_found   = |req;
    if (req[cand1])      rr_pick = cand1;
    else if (req[cand2]) rr_pick = cand2;
    else                 rr_pick = grant;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      grant        <= 2'd2;
      slot_cnt     <= '0;
      gap_cnt      <= '0;
      motor_en_o   <= '0;
      motor_busy_o <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!req[grant] || (slot_cnt == SLOT_LAST && others_req)) begin
            state        <= ST_GAP;
            gap_cnt      <= '0;
            motor_en_o   <= '0;
            motor_busy_o <= 1'b0;
          end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else if (rr_found) begin
            state        <= ST_RUN;
            grant        <= rr_pick;
            slot_cnt     <= '0;
            motor_en_o   <= 3'b001 << rr_pick;
            motor_busy_o <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          if (rr_found) begin
            state        <= ST_RUN;
            grant        <= rr_pick;
            slot_cnt     <= '0;
            motor_en_o   <= 3'b001 << rr_pick;
            motor_busy_o <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lamp_mode_scheduler.sv
// Self-checking bench for lamp_mode_scheduler: a behavioural model is compared
// every cycle, and directed steps pin hand-computed values.
module tb_lamp_mode_scheduler;

  localparam int D = 4;
  localparam int S = 8;
  localparam int G = 2;
  localparam int H = 3;

  logic       clk;
  logic       rst_n;
  logic [9:0] sw;
  logic [2:0] motor_en;
  logic       motor_busy;
  logic [3:0] led;
  logic       led_pwm_sel;
  logic [3:0] mode;

  int total = 0;
  int bad   = 0;

  lamp_mode_scheduler #(
    .DEBOUNCE_CYCLES(D),
    .SLOT_CYCLES(S),
    .GAP_CYCLES(G),
    .BLINK_HALF_CYCLES(H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_i(sw),
    .motor_en_o(motor_en),
    .motor_busy_o(motor_busy),
    .led_o(led),
    .led_pwm_sel_o(led_pwm_sel),
    .mode_o(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: synced inputs, accepted switches, run lengths, blink age, servo owner.
  logic [9:0] m_s1, m_s2, m_deb;
  int         m_run [10];
  int         m_age, m_owner, m_held, m_gap_left, m_last;
  logic [2:0] e_en;
  logic       e_busy, e_sel;
  logic [3:0] e_led, e_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int top;
    logic [2:0] req;
    logic others;
    int pick;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      for (int i = 0; i < 10; i++) m_run[i] = 0;
      m_age = 0; m_owner = -1; m_held = 0; m_gap_left = 0; m_last = 2;
      e_en = '0; e_busy = 1'b0; e_led = '0; e_sel = 1'b0; e_mode = 4'hA;
    end else begin
      e_mode = 4'hA;
      for (int i = 0; i < 10; i++) if (m_deb[i]) e_mode = 4'(i);

      top = -1;
      for (int i = 6; i >= 0; i--) if (top < 0 && m_deb[i]) top = i;
      e_sel = (top == 0);
      case (top)
        6: e_led = 4'b0001;
        5: e_led = 4'b0010;
        4: e_led = 4'b0100;
        3: e_led = 4'b1000;
        2: e_led = 4'b1111;
        1: e_led = (((m_age / H) % 2) == 0) ? 4'b1111 : 4'b0000;
        default: e_led = 4'b0000;
      endcase
      if (top == 1) m_age++;
      else m_age = 0;

      req = {m_deb[7], m_deb[8], m_deb[9]};
      if (m_owner >= 0) begin
        others = |(req & ~(3'b001 << m_owner));
        if (!req[m_owner] || (m_held == S && others)) begin
          m_owner = -1;
          m_gap_left = G - 1;
        end else if (m_held == S) begin
          m_held = 0;
        end
      end else if (m_gap_left > 0) begin
        m_gap_left--;
      end else begin
        pick = -1;
        for (int k = 1; k <= 3; k++)
          if (pick < 0 && req[(m_last + k) % 3]) pick = (m_last + k) % 3;
        if (pick >= 0) begin
          m_owner = pick; m_last = pick; m_held = 0;
        end
      end
      if (m_owner >= 0) begin
        e_en = 3'b001 << m_owner; e_busy = 1'b1; m_held++;
      end else begin
        e_en = '0; e_busy = 1'b0;
      end

      for (int i = 0; i < 10; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_deb[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("motor_en", motor_en, e_en);
      check("motor_busy", motor_busy, e_busy);
      check("led", led, e_led);
      check("led_pwm_sel", led_pwm_sel, e_sel);
      check("mode", mode, e_mode);
      check("en_onehot", ($countones(motor_en) <= 1), 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [2:0] seq_exp;

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    cyc(3);
    check("rst_mode", mode, 4'hA);
    check("rst_led", led, 4'h0);
    check("rst_en", motor_en, 3'b000);
    check("rst_busy", motor_busy, 1'b0);
    check("rst_sel", led_pwm_sel, 1'b0);
    rst_n = 1'b1;

    // Clean edge on SW5: visible on the 7th edge, not the 6th.
    sw[5] = 1'b1;
    cyc(6);
    check("sw5_early_mode", mode, 4'hA);
    cyc(1);
    check("sw5_mode", mode, 4'd5);
    check("sw5_led", led, 4'b0010);
    sw[4] = 1'b1;
    cyc(3);
    sw[4] = 1'b0;
    cyc(10);
    check("bounce_mode", mode, 4'd5);
    check("bounce_led", led, 4'b0010);

    // SW2 over SW1 gives steady on; SW1 alone blinks 3 on / 3 off.
    sw = 10'b0000000110;
    cyc(10);
    check("sw2_led", led, 4'b1111);
    check("sw2_mode", mode, 4'd2);
    sw = 10'b0000000010;
    cyc(7);
    check("blink_first", led, 4'b1111);
    check("blink_mode", mode, 4'd1);
    cyc(2);
    check("blink_on3", led, 4'b1111);
    cyc(1);
    check("blink_off1", led, 4'b0000);
    cyc(3);
    check("blink_on_again", led, 4'b1111);
    cyc(3);
    sw = 10'b0000000110;
    cyc(10);
    sw = 10'b0000000010;
    cyc(7);
    check("blink_reentry_on", led, 4'b1111);
    cyc(3);
    check("blink_reentry_off", led, 4'b0000);

    // SW0 selects PWM fade; SW6 overrides it.
    sw = 10'b0000000001;
    cyc(8);
    check("sw0_sel", led_pwm_sel, 1'b1);
    check("sw0_led", led, 4'b0000);
    check("sw0_mode", mode, 4'd0);
    sw = 10'b0001000001;
    cyc(8);
    check("sw6_sel", led_pwm_sel, 1'b0);
    check("sw6_led", led, 4'b0001);
    check("sw6_mode", mode, 4'd6);

    // Lone servo 0 keeps its enable across slot boundaries.
    sw = 10'b1000000000;
    cyc(7);
    check("sv0_en", motor_en, 3'b001);
    check("sv0_busy", motor_busy, 1'b1);
    check("sv9_mode", mode, 4'd9);
    cyc(20);
    check("sv0_cont", motor_en, 3'b001);
    sw = '0;
    cyc(6);
    check("sv0_hold", motor_en, 3'b001);
    cyc(1);
    check("sv0_drop", motor_en, 3'b000);
    check("sv0_drop_busy", motor_busy, 1'b0);
    cyc(5);

    // From reset, three simultaneous requests rotate 0, 1, 2 with 2-cycle gaps.
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    sw = 10'b1110000000;
    cyc(7);
    for (int k = 0; k < 32; k++) begin
      seq_exp = ((k % 10) < 8) ? (3'b001 << ((k / 10) % 3)) : 3'b000;
      check("rr_seq", motor_en, seq_exp);
      cyc(1);
    end

    // Reset mid-run drops the enable, then a full re-debounce is needed.
    sw = 10'b0100000000;
    cyc(30);
    check("sv1_run", motor_en, 3'b010);
    rst_n = 1'b0;
    cyc(1);
    check("midrst_en", motor_en, 3'b000);
    check("midrst_busy", motor_busy, 1'b0);
    check("midrst_mode", mode, 4'hA);
    rst_n = 1'b1;
    cyc(6);
    check("redeb_wait", motor_en, 3'b000);
    cyc(1);
    check("redeb_en", motor_en, 3'b010);
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
